calc_port_scheduler: RTL
========================

// Module: calc_port_scheduler
// PURPOSE
//  Arbitrates four independent requester ports onto the single shared calculator engine inside the wrapper.
//  Assigns each forwarded command a {port,tag} ID, and tracks up to NTAG outstanding commands per port.
//  Routes each engine response back to the port that issued it.
//  Sits between the per-port bus (tb_if side) and the engine core.
// PARAMETERS
//  NPORT  4   requester ports (fixed 4 in this revision; port ID = 2 bits)
//  NTAG   4   outstanding tags per port (tag = 2 bits)
//  DW     32  operand/result width
// PORTS
//  clk              in   1        system clock, all logic on rising edge
//  reset            in   1        synchronous, active-high
//  req_valid        in   NPORT    per-port command valid
//  req_ready        out  NPORT    per-port command accepted when valid&ready
//  req_cmd          in   NPORT*4  per-port command code (cmd_e)
//  req_op1/req_op2  in   NPORT*DW per-port operands
//  req_tag          out  NPORT*2  tag allocated to the accepted command (valid in accept cycle)
//  eng_valid        out  1        command to engine valid
//  eng_ready        in   1        engine accepts command
//  eng_cmd          out  4        command code
//  eng_op1/eng_op2  out  DW       operands
//  eng_id           out  4        {port[1:0],tag[1:0]}
//  eng_rvalid       in   1        engine response valid (no backpressure)
//  eng_rid          in   4        response ID
//  eng_rresp        in   2        response code (resp_e)
//  eng_rdata        in   DW       result
//  out_valid        out  NPORT    per-port response valid, one-cycle pulse
//  out_resp/out_tag out  NPORT*2  per-port response code / tag
//  out_data         out  NPORT*DW per-port result
//  err_unexp        out  1        sticky: response with ID not outstanding
// BEHAVIOUR
//  Reset
//   - All outputs 0; free-tag bitmaps all 1; RR pointer = port 0; err_unexp = 0.
//   - Engine responses arriving after a mid-operation reset refer to freed IDs and set err_unexp.
//  Issue
//   - Single output register (eng_*), holds value while eng_valid & !eng_ready.
//   - Register may load when empty or draining this cycle (eng_ready).
//   - Eligible port: req_valid=1, at least one free tag, and cmd != CMD_NOP.
//   - RR picks the first eligible port at or after the pointer.
//   - req_ready[p]=1 only for the granted port, combinational; grant only when the register can load.
//   - Accept at cycle N: lowest-index free tag is cleared; eng_valid=1 at N+1.
//   - Pointer moves to grant+1 mod 4 after each accept; unchanged when there is no accept.
//   - CMD_NOP: req_ready[p]=1 immediately regardless of arbitration or tags; nothing forwarded, no tag consumed.
//  Return
//   - eng_rvalid at cycle M with outstanding ID: out_valid[port]=1 at M+1 with resp/data/tag; tag freed at M+1.
//   - Unknown ID: ignored except err_unexp <= 1 (cleared only by reset).
//  Boundaries
//   - Port with all NTAG tags in flight: req_ready=0; other ports keep being served (no head blocking).
//   - Tag freed and same port requesting in the same cycle: freed tag is usable from the next cycle.
//   - A port may re-use a tag only after its response has returned; responses may return out of order.
// STRUCTURE
//  Shared package calc_sched_pkg:
//   - cmd_e: NOP=0, ADD=1, SUB=2, SHL=5, SHR=6
//   - resp_e: NONE=0, OK=1, OVF=2, INV=3
//   - typedefs port_t (2b), tag_t (2b), id_t ({port_t,tag_t}); NPORT and NTAG constants
//  Sub-module rr_arbiter4: request[3:0], advance, grant one-hot, pointer register.
//  Top module holds the tag bitmaps, output register and response demux.
// TESTING
//  1. Reset, single ADD on port 0, eng_ready=1.
//     -> eng_valid at N+1 with eng_id=4'b0000.
//     -> response rid=0 -> out_valid[0] one cycle later, tag 0 freed.
//  2. All 4 ports valid every cycle, eng_ready=1, immediate responses.
//     -> grants go 0,1,2,3,0... with no port skipped.
//  3. Port 2 issues 4 commands without responses.
//     -> 5th request sees req_ready[2]=0; port 3 is still granted.
//     -> return rid=4'b1001 -> tag 1 reallocated on the next accept.
//  4. eng_ready=0 for 5 cycles.
//     -> eng_* stable, no req_ready asserted.
//     -> on release, the held command transfers and the next grant follows the same cycle.
//  5. Response with rid=4'b0111 never issued -> err_unexp=1 and stays set.
//     -> assert reset mid-flight: all outputs 0; err_unexp cleared.
//     -> stale response after reset sets err_unexp again.

Source files
------------

// File: rtl/calc_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc_sched_pkg: shared types and helpers for the calculator port scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
package calc_sched_pkg;

  localparam int NPORT = 4;
  localparam int NTAG  = 4;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_INV  = 2'd3
  } resp_e;

  typedef logic [1:0] port_t;
  typedef logic [1:0] tag_t;

  typedef struct packed {
    port_t port;
    tag_t  tag;
  } id_t;

  function automatic tag_t lowest_free(input logic [NTAG-1:0] free);
    lowest_free = '0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (free[i]) lowest_free = tag_t'(i);
    end
  endfunction

  function automatic port_t onehot_to_port(input logic [NPORT-1:0] oh);
    onehot_to_port = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (oh[i]) onehot_to_port = port_t'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter4: four-way round-robin arbiter, pointer moves past each winner
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] request,
  input  logic       advance,
  output logic [3:0] grant
);

  logic [1:0] ptr_r;
  logic [1:0] idx;
  logic [1:0] grant_idx;

  // Scan from the farthest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = ptr_r;
    idx       = ptr_r;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_r + 2'(i);
      if (request[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= grant_idx + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_port_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc_port_scheduler: arbitrates four requester ports onto one calc engine
// Rev 1.0
// ----------------------------------------------------------------------------
module calc_port_scheduler #(
  parameter int NPORT = 4,
  parameter int NTAG  = 4,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPORT-1:0]    req_valid,
  output logic [NPORT-1:0]    req_ready,
  input  logic [NPORT*4-1:0]  req_cmd,
  input  logic [NPORT*DW-1:0] req_op1,
  input  logic [NPORT*DW-1:0] req_op2,
  output logic [NPORT*2-1:0]  req_tag,
  output logic                eng_valid,
  input  logic                eng_ready,
  output logic [3:0]          eng_cmd,
  output logic [DW-1:0]       eng_op1,
  output logic [DW-1:0]       eng_op2,
  output logic [3:0]          eng_id,
  input  logic                eng_rvalid,
  input  logic [3:0]          eng_rid,
  input  logic [1:0]          eng_rresp,
  input  logic [DW-1:0]       eng_rdata,
  output logic [NPORT-1:0]    out_valid,
  output logic [NPORT*2-1:0]  out_resp,
  output logic [NPORT*2-1:0]  out_tag,
  output logic [NPORT*DW-1:0] out_data,
  output logic                err_unexp
);

  import calc_sched_pkg::*;

  logic [NPORT-1:0] eligible;
  logic [NPORT-1:0] grant;
  logic [NPORT-1:0] ret_hit;
  logic [NTAG-1:0]  free_r [NPORT];
  logic [3:0]       cmd_a  [NPORT];
  logic [DW-1:0]    op1_a  [NPORT];
  logic [DW-1:0]    op2_a  [NPORT];
  tag_t             alloc_tag [NPORT];
  logic             can_load;
  logic             accept;
  logic             rid_known;
  port_t            gport;
  tag_t             gtag;
  id_t              rid;

  assign can_load  = !eng_valid || eng_ready;
  assign accept    = |grant;
  assign gport     = onehot_to_port(grant);
  assign gtag      = alloc_tag[gport];
  assign rid       = id_t'(eng_rid);
  // A cleared free bit means the ID is in flight (held in eng_* or at the engine).
  assign rid_known = !free_r[rid.port][rid.tag];

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign cmd_a[p]     = req_cmd[p*4 +: 4];
    assign op1_a[p]     = req_op1[p*DW +: DW];
    assign op2_a[p]     = req_op2[p*DW +: DW];
    assign alloc_tag[p] = lowest_free(free_r[p]);
    assign eligible[p]  = !reset && can_load && req_valid[p] && (|free_r[p])
                          && (cmd_a[p] != CMD_NOP);
    // NOPs are swallowed on the spot without touching arbitration or tags.
    assign req_ready[p] = grant[p] || (!reset && req_valid[p] && (cmd_a[p] == CMD_NOP));
    assign req_tag[p*2 +: 2] = grant[p] ? alloc_tag[p] : 2'b00;
    assign ret_hit[p]   = eng_rvalid && rid_known && (rid.port == port_t'(p));
  end

  rr_arbiter4 u_arb (
    .clk     (clk),
    .reset   (reset),
    .request (eligible),
    .advance (accept),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      eng_valid <= 1'b0;
      eng_cmd   <= '0;
      eng_op1   <= '0;
      eng_op2   <= '0;
      eng_id    <= '0;
    end else if (can_load) begin
      eng_valid <= accept;
      if (accept) begin
        eng_cmd <= cmd_a[gport];
        eng_op1 <= op1_a[gport];
        eng_op2 <= op2_a[gport];
        eng_id  <= {gport, gtag};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NPORT; p++) free_r[p] <= '1;
      out_valid <= '0;
      out_resp  <= '0;
      out_tag   <= '0;
      out_data  <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (accept) free_r[gport][gtag] <= 1'b0;
      if (eng_rvalid && rid_known) free_r[rid.port][rid.tag] <= 1'b1;
      if (eng_rvalid && !rid_known) err_unexp <= 1'b1;
      out_valid <= ret_hit;
      for (int p = 0; p < NPORT; p++) begin
        if (ret_hit[p]) begin
          out_resp[p*2 +: 2]   <= eng_rresp;
          out_tag[p*2 +: 2]    <= rid.tag;
          out_data[p*DW +: DW] <= eng_rdata;
        end
      end
    end
  end

endmodule
`default_nettype wire
